// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // An index always needs at least one bit, even when there is only one choice.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin picker: first set request after last_grant_i, wrapping.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic [IW-1:0]      winner_o,
    output logic               any_o
);

    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant_i) + i) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port.
// Optional per-grant beat limit enabled by defining FIFO_ARB_MAX_BURST_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BITS      = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                           wr_clk,
    input  logic                           wr_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           fifo_wr_en,
    output logic [BITS-1:0]                fifo_wr_data,
    input  logic                           fifo_wr_full,
    output logic [idx_width(NUM_REQ)-1:0]  grant_id,
    output logic                           busy
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] winner;
    logic          anyValid;
    logic [IW-1:0] sel;
    logic          selected;
    logic          selValid;
    logic          accept;
    logic          selLast;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_o        (anyValid)
    );

    // Outputs are gated by reset so nothing leaks to the FIFO while reset is held.
    assign sel          = (state_q == LOCKED) ? owner_q : winner;
    assign selected     = wr_rst_n && ((state_q == LOCKED) || anyValid);
    assign selValid     = wr_rst_n && ((state_q == LOCKED) ? req_valid[owner_q] : anyValid);
    assign accept       = selValid && !fifo_wr_full;
    assign selLast      = req_last[sel];
    assign fifo_wr_en   = accept;
    assign req_ready    = accept ? (NUM_REQ'(1) << sel) : '0;
    assign fifo_wr_data = selected ? req_data[sel] : '0;
    assign grant_id     = selected ? sel : '0;
    assign busy         = (state_q == LOCKED);

`ifdef FIFO_ARB_MAX_BURST_EN
    localparam int CW = idx_width(MAX_BURST + 1);
    logic [CW-1:0] beat_cnt_q;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (selLast || (MAX_BURST == 1)) begin
                        last_grant_q <= sel;
                    end else begin
                        state_q    <= LOCKED;
                        owner_q    <= sel;
                        beat_cnt_q <= CW'(1);
                    end
                end
                LOCKED: begin
                    // A full beat quota releases the grant even without last.
                    if (selLast || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_q      <= IDLE;
                        last_grant_q <= owner_q;
                        beat_cnt_q   <= '0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (selLast) begin
                        last_grant_q <= sel;
                    end else begin
                        state_q <= LOCKED;
                        owner_q <= sel;
                    end
                end
                LOCKED: begin
                    if (selLast) begin
                        state_q      <= IDLE;
                        last_grant_q <= owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 requesters, 32-bit data).
module tb_fifo_wr_arbiter;

    logic                 wr_clk;
    logic                 wr_rst_n;
    logic [3:0]           req_valid;
    logic [3:0][31:0]     req_data;
    logic [3:0]           req_last;
    logic [3:0]           req_ready;
    logic                 fifo_wr_en;
    logic [31:0]          fifo_wr_data;
    logic                 fifo_wr_full;
    logic [1:0]           grant_id;
    logic                 busy;

    int passCount;
    int checkCount;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .BITS      (32),
        .MAX_BURST (4)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst_n     (wr_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_full (fifo_wr_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [3:0] ready;
        logic       en;
        logic [1:0] grant;
        logic       busy;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic [3:0] r, input logic e, input logic [1:0] g,
                                input logic b);
        vec_t t;
        t.valid = v; t.last = l; t.full = f;
        t.ready = r; t.en = e; t.grant = g; t.busy = b;
        return t;
    endfunction

    function automatic logic [31:0] beatData(input int req, input int row);
        return {8'(req + 1), 8'hA5, 16'(row)};
    endfunction

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic f,
                                 input int row);
        req_valid    = v;
        req_last     = l;
        fifo_wr_full = f;
        for (int i = 0; i < 4; i++) req_data[i] = beatData(i, row);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkAll(input string tag, input logic [3:0] r, input logic e,
                            input logic [1:0] g, input logic b, input logic [31:0] d);
        checkOutput({tag, " req_ready"},    32'(req_ready),  32'(r));
        checkOutput({tag, " fifo_wr_en"},   32'(fifo_wr_en), 32'(e));
        checkOutput({tag, " grant_id"},     32'(grant_id),   32'(g));
        checkOutput({tag, " busy"},         32'(busy),       32'(b));
        checkOutput({tag, " fifo_wr_data"}, fifo_wr_data,    d);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;

        // Single 3-beat burst from requester 0.
        vecs[0]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        vecs[1]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 1);
        vecs[2]  = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 2'd0, 1);
        vecs[3]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        // Everyone sends single beats: rotation 1,2,3,0 (wrap),1.
        vecs[4]  = mk(4'b1111, 4'b1111, 0, 4'b0010, 1, 2'd1, 0);
        vecs[5]  = mk(4'b1111, 4'b1111, 0, 4'b0100, 1, 2'd2, 0);
        vecs[6]  = mk(4'b1111, 4'b1111, 0, 4'b1000, 1, 2'd3, 0);
        vecs[7]  = mk(4'b1111, 4'b1111, 0, 4'b0001, 1, 2'd0, 0);
        vecs[8]  = mk(4'b1111, 4'b1111, 0, 4'b0010, 1, 2'd1, 0);
        // Requester 1 holds a 4-beat burst while requester 2 waits.
        vecs[9]  = mk(4'b0010, 4'b0000, 0, 4'b0010, 1, 2'd1, 0);
        vecs[10] = mk(4'b0110, 4'b0100, 0, 4'b0010, 1, 2'd1, 1);
        vecs[11] = mk(4'b0110, 4'b0100, 0, 4'b0010, 1, 2'd1, 1);
        vecs[12] = mk(4'b0110, 4'b0110, 0, 4'b0010, 1, 2'd1, 1);
        vecs[13] = mk(4'b0100, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        // Requester 3 burst stalled by full for five cycles.
        vecs[14] = mk(4'b1000, 4'b0000, 0, 4'b1000, 1, 2'd3, 0);
        vecs[15] = mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 2'd3, 1);
        vecs[16] = mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 2'd3, 1);
        vecs[17] = mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 2'd3, 1);
        vecs[18] = mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 2'd3, 1);
        vecs[19] = mk(4'b1001, 4'b0000, 1, 4'b0000, 0, 2'd3, 1);
        vecs[20] = mk(4'b1001, 4'b1000, 0, 4'b1000, 1, 2'd3, 1);
        vecs[21] = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        // Owner bubble: requester 0 drops valid mid-burst, requester 1 stays blocked.
        vecs[22] = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
        vecs[23] = mk(4'b0010, 4'b0010, 0, 4'b0000, 0, 2'd0, 1);
        vecs[24] = mk(4'b0011, 4'b0001, 0, 4'b0001, 1, 2'd0, 1);
        vecs[25] = mk(4'b0010, 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        // Full in IDLE must not advance the pointer: requester 2 still wins next.
        vecs[26] = mk(4'b0100, 4'b0100, 1, 4'b0000, 0, 2'd2, 0);
        vecs[27] = mk(4'b1100, 4'b1100, 0, 4'b0100, 1, 2'd2, 0);

        wr_rst_n = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 1'b0, 99);
        repeat (2) @(negedge wr_clk);
        #2;
        checkAll("in_reset", 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            logic [31:0] expData;
            string tag;
            @(negedge wr_clk);
            applyStimulus(vecs[r].valid, vecs[r].last, vecs[r].full, r);
            #2;
            expData = (vecs[r].busy || (vecs[r].valid != 4'b0000)) ?
                      beatData(int'(vecs[r].grant), r) : 32'h0;
            tag = $sformatf("vec%0d", r);
            checkAll(tag, vecs[r].ready, vecs[r].en, vecs[r].grant, vecs[r].busy, expData);
        end

        // Reset mid-burst: requester 3 locks, then reset drops while 0 and 3 are valid.
        @(negedge wr_clk);
        applyStimulus(4'b1000, 4'b0000, 1'b0, 100);
        #2;
        checkAll("rst_lock", 4'b1000, 1'b1, 2'd3, 1'b0, beatData(3, 100));
        @(negedge wr_clk);
        applyStimulus(4'b1001, 4'b0000, 1'b0, 101);
        #1;
        checkOutput("rst_pre busy", 32'(busy), 32'd1);
        wr_rst_n = 1'b0;
        #1;
        checkAll("rst_mid", 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        applyStimulus(4'b1001, 4'b1001, 1'b0, 102);
        #2;
        checkAll("rst_after", 4'b0001, 1'b1, 2'd0, 1'b0, beatData(0, 102));

`ifdef FIFO_ARB_MAX_BURST_EN
        // Quota of 4: req0 gets 4 beats, req1 its 2-beat burst, then req0 finishes.
        begin
            logic [1:0] expG [8];
            logic [3:0] val  [8];
            logic [3:0] lst  [8];
            logic       expB [8];
            expG = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
            val  = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0001};
            lst  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
            expB = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            @(negedge wr_clk);
            wr_rst_n = 1'b0;
            applyStimulus(4'b0000, 4'b0000, 1'b0, 200);
            @(negedge wr_clk);
            wr_rst_n = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge wr_clk);
                applyStimulus(val[c], lst[c], 1'b0, 200 + c);
                #2;
                checkAll($sformatf("quota%0d", c), 4'(1) << expG[c], 1'b1, expG[c],
                         expB[c], beatData(int'(expG[c]), 200 + c));
            end
        end
`endif

        @(negedge wr_clk);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
